instr_prefetch_buffer: RTL and testbench
========================================

Name: instr_prefetch_buffer

Overview:
In-order instruction prefetcher between instruction memory and fetch_stage/decode_stage.
- Issues sequential word fetches ahead of the core, with a bounded number of outstanding requests.
- Buffers returned words together with their PCs in a small FIFO.
- Presents the FIFO head to the core with a valid/stall handshake.
- On a taken branch, flushes the FIFO and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..DEPTH.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous, active-high reset.
imem_req_valid  output  1  request address valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_addr  output  32  word-aligned fetch address.
imem_rsp_valid  input  1  response data valid; responses return in order, latency >= 1 cycle.
imem_rsp_data  input  32  instruction word.
ex_if_branch_taken  input  1  redirect/flush strobe.
ex_if_branch_target  input  32  redirect PC; bits [1:0] ignored.
stall  input  1  consumer not accepting the head.
if_id_valid  output  1  head entry valid.
if_id_instr_data  output  32  head instruction; RV_NOP when invalid.
if_id_pc  output  32  PC of the head instruction.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-high.
- Reset state:
  - fetch_pc = resp_pc = RESET_PC.
  - count, outstanding and discard_cnt = 0.
  - Outputs: imem_req_valid=0, if_id_valid=0, if_id_instr_data=32'h0000_0013, if_id_pc=RESET_PC.
  - Reset mid-operation returns to this state immediately; responses arriving afterwards are not counted and are dropped.
- Request issue:
  - imem_req_valid = !ex_if_branch_taken && outstanding < MAX_OUTSTANDING && (count + outstanding) < DEPTH.
  - This guarantees FIFO space for every accepted request.
  - imem_addr = fetch_pc.
  - When imem_req_valid && imem_req_ready: fetch_pc += 4 and outstanding++.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If discard_cnt > 0: discard_cnt-- and the data is dropped.
  - Otherwise the entry {imem_rsp_data, resp_pc} is pushed and resp_pc += 4.
  - All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Output:
  - Registered FIFO head. if_id_valid = (count != 0).
  - Pop when if_id_valid && !stall. The next entry is visible the following cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Push into an empty FIFO becomes visible the next cycle (1-cycle latency response->output).
  - stall with an empty FIFO has no effect.
- Flush (ex_if_branch_taken=1, highest priority):
  - FIFO is cleared (count=0, pointers reset).
  - fetch_pc = resp_pc = {target[31:2],2'b00}.
  - discard_cnt = outstanding after this cycle's accounting: outstanding minus any response arriving this cycle. Any response arriving this cycle is dropped.
  - No request is issued in the flush cycle.
  - if_id_valid=0 in the next cycle.
  - Back-to-back flushes are legal; the last target wins.
- Full FIFO: no new requests. In-flight responses always fit.

Optional Feature:
PREFETCH_BYPASS_EN
- Defined: when the FIFO is empty, discard_cnt==0 and no flush is active, a valid response drives if_id_valid/if_id_instr_data/if_id_pc combinationally in the same cycle.
  - If !stall it is consumed and not pushed.
  - If stall, it is pushed normally.
- Undefined: 1-cycle response->output latency always; outputs purely registered.

Decomposition:
- Shared package instruction_utils gains:
  - constant RV_NOP = 32'h0000_0013.
  - typedef struct packed {logic [31:0] instr; logic [31:0] pc;} fetch_entry_t.
- One sub-module: prefetch_fifo, a parameterised synchronous FIFO of fetch_entry_t with push/pop/clear, count, empty and full.
- Request/flush control stays in the top block.

Test Plan:
- Reset, memory ready, 1-cycle latency, stall=0 -> requests to 0x0,0x4,0x8…; if_id_valid rises with pc=0x0, instr=mem[0]; one instruction per cycle thereafter.
- stall=1 held 10 cycles with DEPTH=4 -> exactly 4 entries buffered, imem_req_valid=0; release -> pcs 0x0..0xC delivered consecutively with no gap.
- Latency 3, MAX_OUTSTANDING=2, branch to 0x100 while 2 requests are in flight -> both stale responses dropped; next delivered pc=0x100, instr=mem[0x40].
- Branch coinciding with a response and with a request accept -> response dropped, no request that cycle, fetch restarts at target, discard_cnt correct.
- Target 0x0000_0102 -> fetch address 0x100; fetch_pc starting at 0xFFFF_FFFC -> next address 0x0.
- Reset asserted mid-stream with 2 outstanding -> outputs at reset values immediately; late responses are not enqueued.

Source files
------------

// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared instruction-fetch types and constants used by the prefetcher and its FIFO.
package instruction_utils;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Memory-side and core-side signals of the instruction prefetcher.
// master = prefetcher, slave = memory/core environment.
interface instr_prefetch_buffer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ex_if_branch_taken;
  logic [31:0] ex_if_branch_target;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr_data;
  logic [31:0] if_id_pc;

  modport master (
    output imem_req_valid, imem_addr, if_id_valid, if_id_instr_data, if_id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           ex_if_branch_taken, ex_if_branch_target, stall
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_id_valid, if_id_instr_data, if_id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           ex_if_branch_taken, ex_if_branch_target, stall
  );
endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/clear; head is read straight
// from the storage array, so a pushed entry becomes visible the following cycle.
module prefetch_fifo
  import instruction_utils::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_buffer.sv
// In-order instruction prefetcher: sequential word fetches, PC-tagged FIFO, branch flush.
// Optional same-cycle response bypass to the core when built with PREFETCH_BYPASS_EN.
module instr_prefetch_buffer
  import instruction_utils::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  instr_prefetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic [OW-1:0] discard_cnt;
  logic [SW-1:0] occupancy;

  logic flush;
  logic req_valid;
  logic req_fire;
  logic rsp_live;
  logic rsp_keep;
  logic bypass;
  logic push;
  logic pop;

  fetch_entry_t  rsp_entry;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  assign flush = bus.ex_if_branch_taken;

  // A response with nothing outstanding can only be a leftover from before a reset.
  assign rsp_live = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_live && !flush && (discard_cnt == '0);

  // Reserving a slot per outstanding request means every response always fits.
  assign occupancy = {1'b0, count} + SW'(outstanding);
  assign req_valid = !rst && !flush && !full && (outstanding < MAX_OUT) &&
                     (occupancy < SW'(DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(rsp_live);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = rsp_keep && empty;
  assign push   = rsp_keep && !(bypass && !bus.stall);
`else
  assign bypass = 1'b0;
  assign push   = rsp_keep;
`endif

  assign pop       = !empty && !bus.stall;
  assign rsp_entry = '{instr: bus.imem_rsp_data, pc: resp_pc};

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc    <= align_pc(bus.ex_if_branch_target);
      resp_pc     <= align_pc(bus.ex_if_branch_target);
      outstanding <= outstanding_nxt;
      discard_cnt <= outstanding_nxt;
    end else begin
      outstanding <= outstanding_nxt;
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_keep) resp_pc <= resp_pc + 32'd4;
      else if (rsp_live && (discard_cnt != '0)) discard_cnt <= discard_cnt - OW'(1);
    end
  end

  always_comb begin
    bus.if_id_valid      = !empty;
    bus.if_id_instr_data = empty ? RV_NOP : head.instr;
    bus.if_id_pc         = empty ? resp_pc : head.pc;
    if (bypass) begin
      bus.if_id_valid      = 1'b1;
      bus.if_id_instr_data = bus.imem_rsp_data;
      bus.if_id_pc         = resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer (DEPTH=4, MAX_OUTSTANDING=2) with an
// in-order memory model of configurable latency; default build (no bypass).
module tb_instr_prefetch_buffer;
  import instruction_utils::*;

  logic clk = 1'b0;
  logic rst;

  instr_prefetch_buffer_if bus ();

  instr_prefetch_buffer #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int lat      = 1;
  int edge_n   = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[25:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record an accept for the coming edge, clock, then present the
  // memory response due at the following edge.
  task automatic tick();
    #1;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      q_addr.push_back(bus.imem_addr);
      q_due.push_back(edge_n + 1 + lat);
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    if (q_due.size() > 0 && q_due[0] <= edge_n + 1) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                     = 1'b1;
    bus.imem_req_ready      = 1'b1;
    bus.imem_rsp_valid      = 1'b0;
    bus.imem_rsp_data       = 32'h0;
    bus.ex_if_branch_taken  = 1'b0;
    bus.ex_if_branch_target = 32'h0;
    bus.stall               = 1'b0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_if_valid",  32'(bus.if_id_valid), 32'h0);
    check("rst_instr",     bus.if_id_instr_data, 32'h0000_0013);
    check("rst_pc",        bus.if_id_pc, 32'h0);

    // Streaming, latency 1, no stall
    rst = 1'b0;
    #1;
    check("t1_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("t1_addr0", bus.imem_addr, 32'h0);
    tick();
    check("t1_addr1", bus.imem_addr, 32'h4);
    check("t1_valid_e1", 32'(bus.if_id_valid), 32'h0);
    tick();
    check("t1_valid", 32'(bus.if_id_valid), 32'h1);
    check("t1_pc0", bus.if_id_pc, 32'h0);
    check("t1_instr0", bus.if_id_instr_data, 32'hA500_0000);
    tick();
    check("t1_pc4", bus.if_id_pc, 32'h4);
    check("t1_instr4", bus.if_id_instr_data, 32'hA500_0001);
    tick();
    check("t1_pc8", bus.if_id_pc, 32'h8);
    tick();
    check("t1_pcC", bus.if_id_pc, 32'hC);
    check("t1_instrC", bus.if_id_instr_data, 32'hA500_0003);

    // Stall fills the FIFO, then drains without gaps
    rst = 1'b1;
    bus.stall = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("t2_valid_held", 32'(bus.if_id_valid), 32'h1);
    check("t2_pc_held", bus.if_id_pc, 32'h0);
    check("t2_req_blocked", 32'(bus.imem_req_valid), 32'h0);
    check("t2_fetch_pc", bus.imem_addr, 32'h10);
    bus.stall = 1'b0;
    tick();
    check("t2_drain_pc4", bus.if_id_pc, 32'h4);
    check("t2_req_resume", 32'(bus.imem_req_valid), 32'h1);
    tick();
    check("t2_drain_pc8", bus.if_id_pc, 32'h8);
    tick();
    check("t2_drain_pcC", bus.if_id_pc, 32'hC);
    tick();
    check("t2_drain_pc10", bus.if_id_pc, 32'h10);
    check("t2_drain_valid", 32'(bus.if_id_valid), 32'h1);

    // Latency 3: branch with two requests in flight
    rst = 1'b1;
    lat = 3;
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t3_req_limit", 32'(bus.imem_req_valid), 32'h0);
    bus.ex_if_branch_taken  = 1'b1;
    bus.ex_if_branch_target = 32'h0000_0100;
    #1;
    check("t3_flush_no_req", 32'(bus.imem_req_valid), 32'h0);
    tick();
    bus.ex_if_branch_taken = 1'b0;
    check("t3_valid_after_flush", 32'(bus.if_id_valid), 32'h0);
    tick();
    check("t3_addr_target", bus.imem_addr, 32'h100);
    check("t3_req_after_drop", 32'(bus.imem_req_valid), 32'h1);
    tick();
    tick();
    tick();
    check("t3_stale_dropped", 32'(bus.if_id_valid), 32'h0);
    tick();
    check("t3_valid", 32'(bus.if_id_valid), 32'h1);
    check("t3_pc", bus.if_id_pc, 32'h100);
    check("t3_instr", bus.if_id_instr_data, 32'hA500_0040);

    // Branch coincident with a response and a request accept; unaligned target
    check("t4_req_pre", 32'(bus.imem_req_valid), 32'h1);
    check("t4_addr_pre", bus.imem_addr, 32'h108);
    bus.ex_if_branch_taken  = 1'b1;
    bus.ex_if_branch_target = 32'h0000_0102;
    #1;
    check("t4_flush_no_req", 32'(bus.imem_req_valid), 32'h0);
    tick();
    bus.ex_if_branch_taken = 1'b0;
    #1;
    check("t4_valid_cleared", 32'(bus.if_id_valid), 32'h0);
    check("t4_addr_aligned", bus.imem_addr, 32'h100);
    check("t4_req_restart", 32'(bus.imem_req_valid), 32'h1);
    tick();
    tick();
    tick();
    check("t4_not_yet", 32'(bus.if_id_valid), 32'h0);
    tick();
    check("t4_valid", 32'(bus.if_id_valid), 32'h1);
    check("t4_pc", bus.if_id_pc, 32'h100);
    check("t4_instr", bus.if_id_instr_data, 32'hA500_0040);

    // PC wrap-around
    bus.ex_if_branch_taken  = 1'b1;
    bus.ex_if_branch_target = 32'hFFFF_FFFC;
    tick();
    bus.ex_if_branch_taken = 1'b0;
    #1;
    check("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check("t5_addr_wrap", bus.imem_addr, 32'h0);
    tick();
    tick();
    tick();
    check("t5_pc_top", bus.if_id_pc, 32'hFFFF_FFFC);
    check("t5_instr_top", bus.if_id_instr_data, 32'hA5FF_FFFF);
    tick();
    check("t5_pc_wrap", bus.if_id_pc, 32'h0);
    check("t5_instr_wrap", bus.if_id_instr_data, 32'hA500_0000);
    tick();

    // Reset with two requests outstanding; late responses must be ignored
    rst = 1'b1;
    #1;
    check("t6_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("t6_if_valid", 32'(bus.if_id_valid), 32'h0);
    check("t6_instr", bus.if_id_instr_data, 32'h0000_0013);
    check("t6_pc", bus.if_id_pc, 32'h0);
    tick();
    rst = 1'b0;
    bus.imem_req_ready = 1'b0;
    tick();
    tick();
    check("t6_late_dropped", 32'(bus.if_id_valid), 32'h0);
    bus.imem_req_ready = 1'b1;
    #1;
    check("t6_req_after", 32'(bus.imem_req_valid), 32'h1);
    check("t6_addr_after", bus.imem_addr, 32'h0);
    tick();
    check("t6_req_second", 32'(bus.imem_req_valid), 32'h1);
    check("t6_addr_second", bus.imem_addr, 32'h4);
    tick();
    tick();
    tick();
    check("t6_valid", 32'(bus.if_id_valid), 32'h1);
    check("t6_pc0", bus.if_id_pc, 32'h0);
    check("t6_instr0", bus.if_id_instr_data, 32'hA500_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
